// File: rtl/uart_rx_framed.sv
// uart_rx_framed: 16x-oversampled UART receiver (8N1 by default) with start-bit
// glitch rejection, 3-sample majority vote per bit, framing-error and break
// detection, and a 1-entry valid/ready holding register with overrun flag.
//
// Ports:
//   clk        in   system clock, single domain
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   s_tick     in   one-clk enable pulse at 16x baud
//   dout       out  received byte, stable while dout_valid=1
//   dout_valid out  holding register full
//   dout_ready in   consumer accepts dout when dout_valid & dout_ready
//   frame_err  out  1-clk pulse: stop bit sampled 0, byte discarded
//   overrun    out  1-clk pulse: good byte dropped because holding register full
//   brk        out  level: break condition active
module uart_rx_framed #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            frame_err,
   output logic            overrun,
   output logic            brk
);

   localparam int TW = $clog2(SB_TICK) + 1;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_e;

   state_e          state_q, state_d;
   logic            rx_meta_q, rx_s_q;
   logic [TW-1:0]   t_q, t_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic [1:0]      vote_q, vote_d;
   logic            bit_q, bit_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            dv_q, dv_d;
   logic            fe_q, fe_d;
   logic            ov_q, ov_d;
   logic            deliver;
   logic            maj;

   assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      n_d     = n_q;
      shreg_d = shreg_q;
      vote_d  = vote_q;
      bit_d   = bit_q;
      dout_d  = dout_q;
      dv_d    = dv_q;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
      deliver = 1'b0;

      // Vote samples at t=7,8,9; the decided bit is ready well before t=15.
      if (s_tick && (state_q == S_DATA || state_q == S_STOP)) begin
         if (t_q == TW'(7)) vote_d[0] = rx_s_q;
         else if (t_q == TW'(8)) vote_d[1] = rx_s_q;
         else if (t_q == TW'(9)) bit_d = maj;
      end

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               t_d     = '0;
            end
         end
         S_START: begin
            // Glitch check at mid-start; DATA begins at the bit boundary so that
            // its t=7..9 vote window sits in the middle of each data bit.
            if (s_tick) begin
               if (t_q == TW'(7) && rx_s_q) begin
                  state_d = S_IDLE;
               end else if (t_q == TW'(15)) begin
                  state_d = S_DATA;
                  t_d     = '0;
                  n_d     = '0;
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (s_tick) begin
               if (t_q == TW'(15)) begin
                  shreg_d = {bit_q, shreg_q[DBIT-1:1]};
                  t_d     = '0;
                  if (n_q == NW'(DBIT - 1)) state_d = S_STOP;
                  else n_d = n_q + 1'b1;
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (s_tick) begin
               if (t_q == TW'(SB_TICK - 1)) begin
                  t_d = '0;
                  if (bit_q) begin
                     deliver = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     fe_d    = 1'b1;
                     state_d = (shreg_q == '0) ? S_BRK : S_IDLE;
                  end
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
         end
         S_BRK: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (deliver) begin
         if (!dv_q || dout_ready) begin
            dout_d = shreg_q;
            dv_d   = 1'b1;
         end else begin
            ov_d = 1'b1;
         end
      end else if (dv_q && dout_ready) begin
         dv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         t_q       <= '0;
         n_q       <= '0;
         shreg_q   <= '0;
         vote_q    <= '0;
         bit_q     <= 1'b0;
         dout_q    <= '0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         t_q       <= t_d;
         n_q       <= n_d;
         shreg_q   <= shreg_d;
         vote_q    <= vote_d;
         bit_q     <= bit_d;
         dout_q    <= dout_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
         ov_q      <= ov_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;
   assign brk        = (state_q == S_BRK);

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed plus randomized frames driven tick by tick onto
// rx, checked against a frame-level model of the holding register and flags.
module tb_uart_rx_framed;
   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int TPC     = 4;

   logic            clk = 1'b0;
   logic            rst, rx, s_tick, dout_ready;
   logic [DBIT-1:0] dout;
   logic            dout_valid, frame_err, overrun, brk;

   always #5 clk = ~clk;

   uart_rx_framed #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .s_tick     (s_tick),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .brk        (brk)
   );

   int checks = 0;
   int errors = 0;

   // observed events
   logic [7:0] got[$];
   int   fe_cnt = 0, ov_cnt = 0, vhi_cnt = 0;
   logic prev_v = 1'b0, prev_acc = 1'b0;

   // frame-level reference model
   logic [7:0] exp_q[$];
   int   exp_fe = 0, exp_ov = 0;
   logic hold_v = 1'b0;
   logic [7:0] hold_d = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_v   = 1'b0;
         prev_acc = 1'b0;
      end else begin
         if (dout_valid && (!prev_v || prev_acc)) got.push_back(dout);
         if (dout_valid) vhi_cnt++;
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         prev_v   = dout_valid;
         prev_acc = dout_valid && dout_ready;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick_iv(input logic r);
      @(posedge clk); #2;
      rx     = r;
      s_tick = 1'b1;
      repeat (TPC - 1) begin
         @(posedge clk); #2;
         s_tick = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick_iv(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit,
                             input int goff, input int glen, input int lim);
      int   total;
      int   b, o;
      logic lv;
      total = 16 * (DBIT + 1) + SB_TICK;
      for (int j = 0; j < total && j < lim; j++) begin
         if (j < 16) lv = 1'b0;
         else if (j < 16 * (DBIT + 1)) begin
            b  = (j - 16) / 16;
            o  = (j - 16) % 16;
            lv = d[b];
            if (b == gbit && o >= goff && o < goff + glen) lv = ~lv;
         end else lv = stop;
         tick_iv(lv);
      end
   endtask

   task automatic model_frame(input logic [7:0] d, input logic stop);
      if (stop) begin
         if (hold_v && !dout_ready) exp_ov++;
         else begin
            exp_q.push_back(d);
            hold_d = d;
            hold_v = !dout_ready;
         end
      end else begin
         exp_fe++;
      end
   endtask

   task automatic do_frame(input logic [7:0] d, input logic stop, input int gbit,
                           input int goff, input int glen);
      send_frame(d, stop, gbit, goff, glen, 1 << 20);
      model_frame(d, stop);
      idle(3);
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk); #2;
      dout_ready = r;
      if (r) hold_v = 1'b0;
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_nbytes"}, got.size(), exp_q.size());
      chk({tag, "_ferr"}, fe_cnt, exp_fe);
      chk({tag, "_ovr"}, ov_cnt, exp_ov);
   endtask

   initial begin
      int         v0;
      logic [7:0] d;
      logic       stop, r;
      int         gl;

      rst = 1'b1; rx = 1'b1; s_tick = 1'b0; dout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_brk", brk, 0);
      #1 rst = 1'b0;
      idle(4);

      // clean frame, consumer ready
      v0 = vhi_cnt;
      do_frame(8'hA5, 1'b1, -1, 0, 0);
      chk_counts("t1");
      chk("t1_byte", (got.size() > 0) ? got[$] : 8'hxx, 8'hA5);
      chk("t1_valid_width", vhi_cnt - v0, 1);

      // short low pulse in idle is rejected
      repeat (4) tick_iv(1'b0);
      idle(24);
      chk_counts("t2");
      chk("t2_valid", dout_valid, 0);

      // bad stop bit with non-zero data
      do_frame(8'h3C, 1'b0, -1, 0, 0);
      chk_counts("t3");
      chk("t3_valid", dout_valid, 0);
      chk("t3_brk", brk, 0);

      // line held low for 12 bit times
      repeat (12 * 16) tick_iv(1'b0);
      exp_fe++;
      chk_counts("t4");
      chk("t4_brk_on", brk, 1);
      @(posedge clk); #2;
      rx = 1'b1; s_tick = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("t4_brk_hold", brk, 1);
      @(posedge clk);
      #1 chk("t4_brk_off", brk, 0);
      idle(4);
      chk("t4_valid", dout_valid, 0);

      // overrun: consumer stalled across two frames
      set_ready(1'b0);
      do_frame(8'h11, 1'b1, -1, 0, 0);
      do_frame(8'h22, 1'b1, -1, 0, 0);
      chk_counts("t5");
      chk("t5_dout", dout, 8'h11);
      chk("t5_valid", dout_valid, 1);
      set_ready(1'b1);
      @(posedge clk); #2;
      chk("t5_valid_clr", dout_valid, 0);
      chk("t5_dout_hold", dout, 8'h11);

      // glitches inside data bits of a 0x00 frame
      do_frame(8'h00, 1'b1, 3, 8, 1);
      chk("t6_glitch1", (got.size() > 0) ? got[$] : 8'hxx, 8'h00);
      do_frame(8'h00, 1'b1, 5, 9, 2);
      chk("t6_glitch2", (got.size() > 0) ? got[$] : 8'hxx, 8'h00);
      chk_counts("t6");

      // reset mid-frame while a byte is held
      set_ready(1'b0);
      do_frame(8'h77, 1'b1, -1, 0, 0);
      chk("t7_held", dout_valid, 1);
      send_frame(8'h99, 1'b1, -1, 0, 0, 60);
      @(posedge clk); #2;
      rst = 1'b1; rx = 1'b1; s_tick = 1'b0;
      @(posedge clk);
      #1;
      chk("t7_rst_dout", dout, 0);
      chk("t7_rst_valid", dout_valid, 0);
      chk("t7_rst_flags", {frame_err, overrun, brk}, 0);
      #1 rst = 1'b0;
      hold_v = 1'b0;
      idle(20);
      set_ready(1'b1);
      do_frame(8'h5A, 1'b1, -1, 0, 0);
      chk("t7_after", (got.size() > 0) ? got[$] : 8'hxx, 8'h5A);
      chk_counts("t7");

      // randomized frames: data, stop bit, consumer readiness, single-tick noise
      for (int i = 0; i < 24; i++) begin
         r    = ($urandom_range(0, 3) != 0);
         set_ready(r);
         d    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) == 0) begin
            d    = 8'h00;
            stop = 1'b0;
         end
         gl = $urandom_range(0, 1);
         do_frame(d, stop, $urandom_range(0, 7), $urandom_range(0, 15), gl);
         chk("rnd_brk", brk, 0);
      end
      set_ready(1'b1);
      idle(4);
      chk_counts("final");
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("byte%0d", i), got[i], exp_q[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
